// File: rtl/face_detect_scheduler.sv
// Walks one frame's candidate list through the 17x17 threshold unit, one candidate
// in flight at a time, and stores accepted face positions into the result memory.
module face_detect_scheduler #(
  parameter int NUM_CAND_W  = 10,
  parameter int RES_DEPTH_W = 6,
  parameter int TIMEOUT     = 8
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iStart,
  input  logic [NUM_CAND_W-1:0]  iNum_cand,
  output logic [NUM_CAND_W-1:0]  oAddr_CM,
  input  logic [44:0]            iData_CM,
  output logic                   oThr_input_ready,
  output logic [12:0]            oThr_position,
  output logic [31:0]            oThr_max_val,
  output logic                   oThr_finish,
  input  logic                   iThr_output_ready,
  input  logic [12:0]            iThr_position,
  input  logic                   iThr_end,
  output logic                   oWe_RM,
  output logic [RES_DEPTH_W-1:0] oAddr_RM,
  output logic [12:0]            oData_RM,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [RES_DEPTH_W:0]   oFace_count,
  output logic                   oOverflow
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT_DATA, S_ISSUE, S_CHECK,
    S_WAIT_RES, S_WRITE, S_NEXT, S_FINISH, S_DONE
  } state_t;

  state_t                  state_q;
  logic [NUM_CAND_W-1:0]   num_q;
  logic [NUM_CAND_W-1:0]   idx_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [NUM_CAND_W-1:0]   addr_cm_q;
  logic                    thr_rdy_q;
  logic [12:0]             thr_pos_q;
  logic [31:0]             thr_max_q;
  logic                    thr_fin_q;
  logic                    we_q;
  logic [RES_DEPTH_W-1:0]  addr_rm_q;
  logic [12:0]             data_rm_q;
  logic                    busy_q;
  logic                    done_q;
  logic [RES_DEPTH_W:0]    cnt_q;
  logic                    ovf_q;

  // Terminal test done one bit wider so the compare precedes the increment.
  logic [NUM_CAND_W:0]     idx_inc_d;
  logic                    last_d;
  logic                    rm_full_d;

  assign idx_inc_d = {1'b0, idx_q} + (NUM_CAND_W+1)'(1);
  assign last_d    = (idx_inc_d == {1'b0, num_q});
  assign rm_full_d = cnt_q[RES_DEPTH_W];

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      addr_cm_q <= '0;
      thr_rdy_q <= 1'b0;
      thr_pos_q <= '0;
      thr_max_q <= '0;
      thr_fin_q <= 1'b0;
      we_q      <= 1'b0;
      addr_rm_q <= '0;
      data_rm_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      thr_rdy_q <= 1'b0;
      thr_fin_q <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (iStart) begin
          num_q     <= iNum_cand;
          idx_q     <= '0;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
          busy_q    <= 1'b1;
          addr_cm_q <= '0;
          if (iNum_cand == '0) begin
            thr_fin_q <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          thr_max_q <= iData_CM[44:13];
          thr_pos_q <= iData_CM[12:0];
          thr_rdy_q <= 1'b1;
          state_q   <= S_ISSUE;
        end
        S_ISSUE: begin
          tmr_q   <= '0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          tmr_q   <= tmr_q + 1'b1;
          state_q <= iThr_end ? S_NEXT : S_WAIT_RES;
        end
        S_WAIT_RES: begin
          // A result arriving on the timeout cycle still counts.
          if (iThr_output_ready) begin
            state_q <= S_WRITE;
            if (!rm_full_d) begin
              we_q      <= 1'b1;
              addr_rm_q <= cnt_q[RES_DEPTH_W-1:0];
              data_rm_q <= iThr_position;
              cnt_q     <= cnt_q + 1'b1;
            end else begin
              ovf_q     <= 1'b1;
            end
          end else if (tmr_q >= TMR_W'(TIMEOUT - 1)) begin
            state_q <= S_NEXT;
          end else begin
            tmr_q   <= tmr_q + 1'b1;
          end
        end
        S_WRITE: state_q <= S_NEXT;
        S_NEXT: begin
          idx_q <= idx_inc_d[NUM_CAND_W-1:0];
          if (last_d) begin
            thr_fin_q <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            addr_cm_q <= idx_inc_d[NUM_CAND_W-1:0];
            state_q   <= S_FETCH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oAddr_CM         = addr_cm_q;
  assign oThr_input_ready = thr_rdy_q;
  assign oThr_position    = thr_pos_q;
  assign oThr_max_val     = thr_max_q;
  assign oThr_finish      = thr_fin_q;
  assign oWe_RM           = we_q;
  assign oAddr_RM         = addr_rm_q;
  assign oData_RM         = data_rm_q;
  assign oBusy            = busy_q;
  assign oDone            = done_q;
  assign oFace_count      = cnt_q;
  assign oOverflow        = ovf_q;

endmodule

// File: tb/tb_face_detect_scheduler.sv
// Scoreboarded bench: CM and threshold-unit models drive the scheduler; expected
// issues and RM writes are queued up front and popped as the DUT produces them.
module tb_face_detect_scheduler;
  localparam int NCW = 10, RDW = 2, TO = 8;
  localparam int REJ = 0, ACC = 1, NORESP = 2, REJS = 3;

  logic            iClk = 1'b0, iReset = 1'b1, iStart = 1'b0;
  logic [NCW-1:0]  iNum_cand = '0;
  logic [44:0]     iData_CM = '0;
  logic            iThr_output_ready = 1'b0, iThr_end = 1'b0;
  logic [12:0]     iThr_position = '0;
  logic [NCW-1:0]  oAddr_CM;
  logic            oThr_input_ready, oThr_finish, oWe_RM, oBusy, oDone, oOverflow;
  logic [12:0]     oThr_position, oData_RM;
  logic [31:0]     oThr_max_val;
  logic [RDW-1:0]  oAddr_RM;
  logic [RDW:0]    oFace_count;

  face_detect_scheduler #(.NUM_CAND_W(NCW), .RES_DEPTH_W(RDW), .TIMEOUT(TO)) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iNum_cand(iNum_cand),
    .oAddr_CM(oAddr_CM), .iData_CM(iData_CM),
    .oThr_input_ready(oThr_input_ready), .oThr_position(oThr_position),
    .oThr_max_val(oThr_max_val), .oThr_finish(oThr_finish),
    .iThr_output_ready(iThr_output_ready), .iThr_position(iThr_position),
    .iThr_end(iThr_end), .oWe_RM(oWe_RM), .oAddr_RM(oAddr_RM), .oData_RM(oData_RM),
    .oBusy(oBusy), .oDone(oDone), .oFace_count(oFace_count), .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  logic [44:0]      cm_mem [0:1023];
  logic [44:0]      iss_q [$];
  logic [RDW+12:0]  wr_q  [$];
  int               mode_tbl [16];
  logic [12:0]      pos_tbl  [16];
  int               iss_cyc  [16];
  int n_cmp = 0, n_err = 0;
  int n_issue = 0, n_fin = 0, n_done = 0, fin_base = 0;
  int iss_ord = 0, cyc = 0, salt = 0;
  int k = 0, cur_mode = NORESP;
  bit active = 1'b0;
  logic [12:0] cur_pos = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CM with one-cycle read latency
  always @(posedge iClk) iData_CM <= cm_mem[oAddr_CM];

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  // Threshold-unit model plus output monitor, both on the falling edge
  initial forever begin
    @(negedge iClk);
    if (iReset) begin
      active = 1'b0;
      iThr_end = 1'b0;
      iThr_output_ready = 1'b0;
    end else begin
      if (oThr_input_ready) begin
        n_issue++;
        if (iss_q.size() == 0) chk("issue_unexpected", 64'(1), 64'(0));
        else chk("issue_data", 64'({oThr_max_val, oThr_position}), 64'(iss_q.pop_front()));
        if (iss_ord < 16) begin
          cur_mode = mode_tbl[iss_ord];
          cur_pos  = pos_tbl[iss_ord];
          iss_cyc[iss_ord] = cyc;
        end
        iss_ord++;
        active = 1'b1;
        k = 0;
      end else if (active && k < 100) k++;
      iThr_end          = active && (cur_mode == REJ || cur_mode == REJS) && k == 1;
      iThr_output_ready = active && (cur_mode == ACC || cur_mode == REJS) && k == 3;
      iThr_position     = cur_pos;
      if (oWe_RM) begin
        if (wr_q.size() == 0) chk("rm_write_unexpected", 64'({oAddr_RM, oData_RM}), 64'(0));
        else chk("rm_write", 64'({oAddr_RM, oData_RM}), 64'(wr_q.pop_front()));
      end
      if (oThr_finish) n_fin++;
      if (oDone) begin
        n_done++;
        chk("finish_before_done", 64'(n_fin - fin_base), 64'(1));
      end
    end
  end

  task automatic load_cm(input int n);
    for (int i = 0; i < n; i++) begin
      cm_mem[i] = {32'hC0DE_0000 + 32'(salt * 64 + i), 13'(13'h040 + 13'(i * 3 + salt))};
      iss_q.push_back(cm_mem[i]);
    end
    salt++;
  endtask

  task automatic push_wr(input int addr, input int pos);
    wr_q.push_back({RDW'(addr), 13'(pos)});
  endtask

  task automatic run_frame(input int n, input int exp_cnt, input bit exp_ovf,
                           input int dup_at, input string nm, output int lat);
    int d0, f0, i0;
    bit got;
    @(posedge iClk);
    load_cm(n);
    iss_ord = 0;
    d0 = n_done; f0 = n_fin; i0 = n_issue; fin_base = n_fin;
    @(negedge iClk);
    iStart = 1'b1;
    iNum_cand = NCW'(n);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 2000) begin
      @(negedge iClk);
      iStart = (dup_at > 0 && lat == dup_at);
      if (iStart) iNum_cand = NCW'(5);
      @(posedge iClk);
      #1;
      lat++;
      got = (n_done != d0);
    end
    iStart = 1'b0;
    chk({nm, "_done_seen"}, 64'(got), 64'(1));
    repeat (10) @(negedge iClk);
    chk({nm, "_face_count"}, 64'(oFace_count), 64'(exp_cnt));
    chk({nm, "_overflow"}, 64'(oOverflow), 64'(exp_ovf));
    chk({nm, "_busy_low"}, 64'(oBusy), 64'(0));
    chk({nm, "_finish_once"}, 64'(n_fin - f0), 64'(1));
    chk({nm, "_done_once"}, 64'(n_done - d0), 64'(1));
    chk({nm, "_issues"}, 64'(n_issue - i0), 64'(n));
    chk({nm, "_iss_q_empty"}, 64'(iss_q.size()), 64'(0));
    chk({nm, "_wr_q_empty"}, 64'(wr_q.size()), 64'(0));
  endtask

  initial begin
    int lat, t, f0, i0;
    for (int i = 0; i < 1024; i++) cm_mem[i] = '0;
    for (int i = 0; i < 16; i++) begin mode_tbl[i] = NORESP; pos_tbl[i] = '0; end

    repeat (3) @(negedge iClk);
    chk("reset_a", 64'({oThr_max_val, oThr_position, oAddr_CM}), 64'(0));
    chk("reset_b", 64'({oThr_input_ready, oThr_finish, oWe_RM, oAddr_RM, oData_RM,
                        oBusy, oDone, oFace_count, oOverflow}), 64'(0));
    iReset = 1'b0;
    repeat (2) @(negedge iClk);

    // Abort mid-WAIT_RES with reset
    @(posedge iClk);
    load_cm(3);
    iss_ord = 0;
    f0 = n_fin; i0 = n_issue;
    @(negedge iClk); iStart = 1'b1; iNum_cand = NCW'(3);
    @(negedge iClk); iStart = 1'b0;
    t = 0;
    while (n_issue == i0 && t < 50) begin @(posedge iClk); #1; t++; end
    chk("rst_issue_seen", 64'(n_issue != i0), 64'(1));
    repeat (2) @(negedge iClk);
    chk("busy_before_reset", 64'(oBusy), 64'(1));
    iReset = 1'b1;
    #1;
    chk("midrst_a", 64'({oThr_max_val, oThr_position, oAddr_CM}), 64'(0));
    chk("midrst_b", 64'({oThr_input_ready, oThr_finish, oWe_RM, oAddr_RM, oData_RM,
                         oBusy, oDone, oFace_count, oOverflow}), 64'(0));
    repeat (3) @(negedge iClk);
    iss_q.delete();
    wr_q.delete();
    iReset = 1'b0;
    repeat (2) @(negedge iClk);
    chk("rst_no_finish", 64'(n_fin - f0), 64'(0));

    // Reject, accept, accept
    mode_tbl[0] = REJ; mode_tbl[1] = ACC; mode_tbl[2] = ACC;
    pos_tbl[1] = 13'h0A2; pos_tbl[2] = 13'h100;
    push_wr(0, 'h0A2); push_wr(1, 'h100);
    run_frame(3, 2, 1'b0, 0, "basic", lat);
    chk("gap_reject", 64'(iss_cyc[1] - iss_cyc[0]), 64'(5));
    chk("gap_accept", 64'(iss_cyc[2] - iss_cyc[1]), 64'(8));

    // Empty frame
    run_frame(0, 0, 1'b0, 0, "empty", lat);
    chk("empty_latency_le3", 64'(lat <= 3), 64'(1));

    // RM overflow: six accepts into a four-entry RM
    for (int i = 0; i < 6; i++) begin mode_tbl[i] = ACC; pos_tbl[i] = 13'(13'h010 + 13'(i)); end
    for (int i = 0; i < 4; i++) push_wr(i, 'h010 + i);
    run_frame(6, 4, 1'b1, 0, "ovf", lat);

    // No response for the middle candidate
    mode_tbl[0] = ACC; mode_tbl[1] = NORESP; mode_tbl[2] = ACC;
    pos_tbl[0] = 13'h055; pos_tbl[1] = 13'h0EE; pos_tbl[2] = 13'h077;
    push_wr(0, 'h055); push_wr(1, 'h077);
    run_frame(3, 2, 1'b0, 0, "timeout", lat);
    chk("gap_timeout", 64'(iss_cyc[2] - iss_cyc[1]), 64'(TO + 4));

    // Restart attempt while busy; stray result pulse lands in FETCH
    mode_tbl[0] = REJS; mode_tbl[1] = ACC;
    pos_tbl[0] = 13'h1FF; pos_tbl[1] = 13'h033;
    push_wr(0, 'h033);
    run_frame(2, 1, 1'b0, 3, "busy_start", lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/face_detect_scheduler.md
Name: face_detect_scheduler

Overview:
- Sequences the 17x17 threshold/verification stage over one frame's list of candidate windows.
- Candidates are (position, max correlation value) pairs from the candidate memory (CM). The block fetches each one and issues it to the threshold unit.
- It resolves each candidate as accepted or rejected, and writes accepted face positions into the result memory (RM).
- At frame end it clears the threshold unit and reports the face count to the host/display side.

Parameters:
- NUM_CAND_W, 10, width of candidate count/address (max 1023 candidates).
- RES_DEPTH_W, 6, width of result address; RM holds 2**RES_DEPTH_W faces.
- TIMEOUT, 8, cycles allowed from issue to threshold-unit response before a candidate is forced rejected.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle pulse; begin a frame scan; ignored unless idle.
- iNum_cand  in  NUM_CAND_W  candidates to process; sampled on accepted iStart.
- oAddr_CM  out  NUM_CAND_W  CM read address.
- iData_CM  in  45  CM read data, 1-cycle latency; [44:13]=max_val, [12:0]=position.
- oThr_input_ready  out  1  one-cycle issue strobe to threshold unit.
- oThr_position  out  13  candidate position to threshold unit.
- oThr_max_val  out  32  candidate max value to threshold unit.
- oThr_finish  out  1  one-cycle clear pulse to threshold unit.
- iThr_output_ready  in  1  threshold unit result-valid pulse.
- iThr_position  in  13  threshold unit result position.
- iThr_end  in  1  threshold unit reject level.
- oWe_RM  out  1  RM write enable.
- oAddr_RM  out  RES_DEPTH_W  RM write address.
- oData_RM  out  13  RM write data (face position).
- oBusy  out  1  high from accepted iStart until oDone.
- oDone  out  1  one-cycle pulse at end of frame.
- oFace_count  out  RES_DEPTH_W+1  faces stored this frame; valid from oDone until next iStart.
- oOverflow  out  1  sticky per frame; an accepted face was dropped because RM was full.

Behaviour:
- Reset values (asynchronous): every output is 0, and the state is IDLE. Reset mid-frame aborts immediately; oThr_finish is not generated.
- IDLE: on iStart, latch iNum_cand and clear cand_idx, oFace_count and oOverflow. oBusy goes high next cycle.
  - If iNum_cand==0, go to FINISH.
  - Otherwise go to FETCH.
- FETCH: drive oAddr_CM=cand_idx, then go to WAIT_DATA.
- WAIT_DATA: register iData_CM into oThr_max_val and oThr_position, then go to ISSUE.
- ISSUE: assert oThr_input_ready for exactly one cycle, clear the timeout counter, then go to CHECK.
- CHECK (one cycle after the issue edge): sample iThr_end.
  - If iThr_end=1, the candidate is rejected; go to NEXT.
  - Otherwise go to WAIT_RES.
- WAIT_RES: wait for iThr_output_ready (nominally 3 cycles after issue).
  - On the pulse, go to WRITE holding iThr_position.
  - If the counter reaches TIMEOUT with no pulse, reject and go to NEXT.
  - If iThr_output_ready and the timeout coincide, the result wins.
- WRITE:
  - If oFace_count < 2**RES_DEPTH_W: pulse oWe_RM with oAddr_RM=oFace_count[RES_DEPTH_W-1:0] and oData_RM=held position, then increment oFace_count.
  - Otherwise set oOverflow and do not write.
  - Go to NEXT.
- NEXT: increment cand_idx.
  - If cand_idx+1 == latched count, go to FINISH.
  - Otherwise go to FETCH.
- FINISH: pulse oThr_finish for one cycle, then go to DONE.
- DONE: pulse oDone, drop oBusy, return to IDLE.
- Issue rules: only one candidate is in flight at a time. oThr_input_ready never asserts outside ISSUE. A stray iThr_output_ready outside WAIT_RES is ignored.
- Throughput: a rejected candidate takes 5 cycles (FETCH..NEXT). An accepted candidate takes 8 cycles with nominal 3-cycle response.
- iStart while busy is ignored and iNum_cand is not resampled. iStart in the same cycle as oDone is also ignored.
- Widths: cand_idx is NUM_CAND_W bits and never wraps; the terminal compare precedes increment. oFace_count saturates at 2**RES_DEPTH_W.

Test Plan:
- Reset high mid-WAIT_RES -> all outputs 0 immediately; after release, iStart with 3 candidates starts cleanly at cand_idx 0.
- iNum_cand=3; threshold model rejects #0 (iThr_end=1), accepts #1 (pos 0x0A2), accepts #2 (pos 0x100) -> RM[0]=0x0A2, RM[1]=0x100, oFace_count=2, one oThr_finish, oDone after it, oOverflow=0.
- iNum_cand=0 -> oThr_finish and oDone within 3 cycles of iStart; no oThr_input_ready, no CM reads, oFace_count=0.
- RES_DEPTH_W=2, 6 candidates all accepted -> 4 RM writes (addr 0..3), oFace_count=4, oOverflow=1, scan still completes all 6 issues.
- Threshold model never responds for candidate #1 (iThr_end=0, no output_ready) -> rejected after TIMEOUT=8 cycles, candidate #2 issued next, no RM write for #1.
- iStart pulsed during busy with iNum_cand=5, original 2 -> exactly 2 issues, oDone once; stray iThr_output_ready in FETCH produces no RM write.
